// File: rtl/pairsum_product_seq.sv
// Sequential product of the first k pair sums (a_i + b_i), one multiply per clock.
// The operand bundle and the result each use a valid/ready handshake.
`timescale 1ns/1ps

module pairsum_product_seq #(
  parameter  int W  = 8,
  parameter  int N  = 3,
  localparam int LW = $clog2(N + 1),
  localparam int PW = N * (W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  a_bus,
  input  logic [N*W-1:0]  b_bus,
  input  logic [LW-1:0]   len,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   out_data,
  output logic            len_err
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state_q;
  logic [W:0]    sum_q [N];
  logic [LW-1:0] k_q;
  logic [LW-1:0] idx_q;
  logic [PW-1:0] acc_q;
  logic [PW-1:0] out_data_q;
  logic          out_valid_q;
  logic          len_err_q;

  logic [W:0]    sum_d [N];
  logic [LW-1:0] k_d;
  logic          len_err_d;
  logic [LW:0]   len_ext;
  logic [PW-1:0] mul_op;
  logic [PW-1:0] acc_d;
  logic          last_step;

  // Accept-side decode: full-width pair sums and the clamped multiply count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    k_d       = len;
    len_err_d = 1'b0;
    len_ext   = {1'b0, len};
    for (int i = 0; i < N; i++) begin
      sum_d[i] = {1'b0, a_bus[i*W +: W]} + {1'b0, b_bus[i*W +: W]};
    end
    if (len == '0) begin
      k_d       = LW'(1);
      len_err_d = 1'b1;
    end else if (len_ext > (LW + 1)'(N)) begin
      k_d       = LW'(N);
      len_err_d = 1'b1;
    end
  end

  // Operand selection by index; a mux avoids indexing past N-1 when N is not a power of two.
  always_comb begin
    mul_op = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == LW'(i)) mul_op = PW'(sum_q[i]);
    end
    acc_d     = acc_q * mul_op;
    last_step = (idx_q == k_q - LW'(1));
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign len_err   = len_err_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // NOTE: sum_q is left out of reset; it is always written on accept before any read.
            sum_q     <= sum_d;
            k_q       <= k_d;
            len_err_q <= len_err_d;
            acc_q     <= PW'(sum_d[0]);
            idx_q     <= LW'(1);
            if (k_d == LW'(1)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= PW'(sum_d[0]);
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q <= acc_d;
          idx_q <= idx_q + LW'(1);
          if (last_step) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pairsum_product_seq.sv
// Self-checking bench for pairsum_product_seq: directed vector table, reset and
// backpressure sequences, random traffic against a reference model, and N=1 / N=8 instances.
`timescale 1ns/1ps

module tb_pairsum_product_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Default instance: W=8, N=3.
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, len_err;
  logic [23:0] a_bus = '0, b_bus = '0;
  logic [1:0]  len = '0;
  logic [26:0] out_data;

  pairsum_product_seq #(.W(8), .N(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_bus(a_bus), .b_bus(b_bus), .len(len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .len_err(len_err));

  // W=4, N=1 instance.
  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic       in_ready1, out_valid1, len_err1;
  logic [3:0] a_bus1 = '0, b_bus1 = '0;
  logic       len1 = 1'b0;
  logic [4:0] out_data1;

  pairsum_product_seq #(.W(4), .N(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_bus(a_bus1), .b_bus(b_bus1), .len(len1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .len_err(len_err1));

  // W=8, N=8 instance.
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic        in_ready8, out_valid8, len_err8;
  logic [63:0] a_bus8 = '0, b_bus8 = '0;
  logic [3:0]  len8 = '0;
  logic [71:0] out_data8;

  pairsum_product_seq #(.W(8), .N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_bus(a_bus8), .b_bus(b_bus8), .len(len8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .len_err(len_err8));

  typedef struct {
    string       name;
    logic [23:0] a;
    logic [23:0] b;
    logic [1:0]  len;
    int          delay;
    longint      exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: product of the first k pair sums, k being len clamped into 1..3.
  function automatic longint ref_product(input logic [23:0] a, input logic [23:0] b,
                                         input int l, output bit err, output int k);
    longint p = 1;
    err = (l < 1) || (l > 3);
    k   = (l < 1) ? 1 : ((l > 3) ? 3 : l);
    for (int i = 0; i < k; i++) p = p * (longint'(a[i*8 +: 8]) + longint'(b[i*8 +: 8]));
    return p;
  endfunction

  task automatic run3(input vec_t v);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    check({v.name, " in_ready before accept"}, 128'(in_ready), 128'(1));
    a_bus = v.a; b_bus = v.b; len = v.len; in_valid = 1'b1;
    out_ready = (v.delay == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_bus = 24'($urandom); b_bus = 24'($urandom); len = 2'($urandom);
    check({v.name, " in_ready after accept"}, 128'(in_ready), 128'(0));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check({v.name, " latency"}, 128'(n), 128'(v.exp_lat));
    check({v.name, " out_data"}, 128'(out_data), 128'(v.exp_data));
    check({v.name, " len_err"}, 128'(len_err), 128'(v.exp_err));
    for (int d = 0; d < v.delay; d++) begin
      in_valid = d[0];
      @(posedge clk); #1;
      check({v.name, " held out_valid"}, 128'(out_valid), 128'(1));
      check({v.name, " held out_data"}, 128'(out_data), 128'(v.exp_data));
      check({v.name, " held len_err"}, 128'(len_err), 128'(v.exp_err));
      check({v.name, " held in_ready"}, 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({v.name, " out_valid after handshake"}, 128'(out_valid), 128'(0));
    check({v.name, " in_ready after handshake"}, 128'(in_ready), 128'(1));
    out_ready = 1'b0;
  endtask

  task automatic run8(input string nm, input logic [3:0] l, input longint exp_d,
                      input bit exp_e, input int exp_lat);
    int n = 0;
    a_bus8 = {8{8'd1}}; b_bus8 = {8{8'd1}}; len8 = l; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
    check({nm, " latency"}, 128'(n), 128'(exp_lat));
    check({nm, " out_data"}, 128'(out_data8), 128'(exp_d));
    check({nm, " len_err"}, 128'(len_err8), 128'(exp_e));
    @(posedge clk); #1;
    check({nm, " in_ready after handshake"}, 128'(in_ready8), 128'(1));
  endtask

  task automatic run1(input string nm, input logic l, input bit exp_e);
    int n = 0;
    a_bus1 = 4'd15; b_bus1 = 4'd15; len1 = l; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    while (!out_valid1 && n < 20) begin @(posedge clk); #1; n++; end
    check({nm, " latency"}, 128'(n), 128'(0));
    check({nm, " out_data"}, 128'(out_data1), 128'(30));
    check({nm, " len_err"}, 128'(len_err1), 128'(exp_e));
    @(posedge clk); #1;
    check({nm, " out_valid pulse"}, 128'(out_valid1), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   e;
    int   k;

    vecs[0] = '{"two_pairs",  24'h00030A, 24'h000414, 2'd2, 0, 210,       1'b0, 1};
    vecs[1] = '{"full_scale", 24'hFFFFFF, 24'hFFFFFF, 2'd3, 0, 132651000, 1'b0, 2};
    vecs[2] = '{"len1",       24'h000005, 24'h000006, 2'd1, 0, 11,        1'b0, 0};
    vecs[3] = '{"len0_clamp", 24'h000005, 24'h000006, 2'd0, 0, 11,        1'b1, 0};
    vecs[4] = '{"sums_2_3_4", 24'h010101, 24'h030201, 2'd3, 0, 24,        1'b0, 2};
    vecs[5] = '{"backpress",  24'h050403, 24'h000000, 2'd3, 5, 60,        1'b0, 2};
    vecs[6] = '{"len2_skip3", 24'hFF0201, 24'h010101, 2'd2, 2, 6,         1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset out_data", 128'(out_data), 128'(0));
    check("reset len_err", 128'(len_err), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("in_ready after reset", 128'(in_ready), 128'(1));

    for (int i = 0; i < 7; i++) run3(vecs[i]);

    // Reset while in MUL: the in-flight result must never appear.
    a_bus = 24'hFFFFFF; b_bus = 24'hFFFFFF; len = 2'd3; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst out_valid", 128'(out_valid), 128'(0));
    check("midrst out_data", 128'(out_data), 128'(0));
    check("midrst len_err", 128'(len_err), 128'(0));
    check("midrst in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst no late result", 128'(out_valid), 128'(0));
    end
    out_ready = 1'b0;
    v = '{"after_reset", 24'h030201, 24'h030201, 2'd3, 0, 48, 1'b0, 2};
    run3(v);

    for (int t = 0; t < 40; t++) begin
      v.name    = "random";
      v.a       = 24'($urandom);
      v.b       = 24'($urandom);
      v.len     = 2'($urandom_range(0, 3));
      v.delay   = $urandom_range(0, 3);
      v.exp_data = ref_product(v.a, v.b, int'(v.len), e, k);
      v.exp_err = e;
      v.exp_lat = k - 1;
      run3(v);
    end

    run1("n1_len1", 1'b1, 1'b0);
    run1("n1_len0", 1'b0, 1'b1);

    run8("n8_len8",  4'd8,  256, 1'b0, 7);
    run8("n8_len12", 4'd12, 256, 1'b1, 7);
    run8("n8_len0",  4'd0,  2,   1'b1, 0);
    run8("n8_len5",  4'd5,  32,  1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
